toggle_ff_posedge: RTL and testbench
====================================

// Module: toggle_ff_posedge
// PURPOSE
//   Bank of WIDTH independent T (toggle) flip-flops clocked on the rising edge of clk.
//   Each bit holds when its T input is 0 and inverts when T is 1.
//   Basic sequential primitive for counters, dividers and parity trackers.
//   Default configuration (WIDTH=1) is a single T flip-flop.
// PARAMETERS
//   WIDTH      1    number of independent toggle bits (>=1)
//   RESET_VAL  0    WIDTH-bit value loaded into Q by reset
// PORTS
//   clk          input   1      rising-edge clock; sole clock of the block
//   reset_async  input   1      reset, synchronous, active-high (1 = reset, sampled on posedge clk)
//   T            input   WIDTH  per-bit toggle request
//   Q            output  WIDTH  registered state
//   Q_n          output  WIDTH  bitwise complement of Q, combinational from Q
// BEHAVIOUR
//   - One clock domain; all state updates occur only on posedge clk.
//   - Reset is synchronous, despite the port name:
//       reset_async==1 at posedge clk -> Q <= RESET_VAL at that edge; T is ignored.
//       Reset asserted between edges has no effect until the next posedge.
//   - Reset values: Q = RESET_VAL (default 0); Q_n = ~RESET_VAL.
//   - Normal operation (reset_async==0 at posedge clk), for each bit i:
//       T[i]==0 -> Q[i] <= Q[i]     (hold)
//       T[i]==1 -> Q[i] <= ~Q[i]    (toggle)
//     Equivalent form: Q <= Q ^ T.
//   - Timing and hazards:
//       Latency is 1 clock: T sampled at edge k affects Q immediately after edge k.
//       There is no combinational path from T to Q.
//       Q_n is always exactly ~Q, with no registered delay and no glitch budget beyond the inverter.
//   - Bits are fully independent; there is no carry or interaction between bits.
//   - Power-up before the first reset: Q is undefined (X in simulation).
//     Users must apply reset for at least one posedge before relying on Q.
//   - Simultaneous reset and T=1 at the same edge: reset wins, Q = RESET_VAL.
//   - Reset asserted mid-sequence: Q returns to RESET_VAL at the next edge.
//     Toggling resumes from RESET_VAL on the first edge after reset deasserts.
//   - T changing between edges has no effect; only the value at the edge matters.
//   - Toggle register only: no enable, no handshake, no saturation, no wrap logic.
// TESTING
//   Checker: sample Q just after each posedge and compare against Q_prev captured before that edge.
//   Required results, in order:
//   1. Reset: hold reset_async=1 for one edge, T=1 -> Q=0, Q_n=1 after the edge.
//      Repeat with RESET_VAL=1 -> Q=1.
//   2. Hold: reset_async=0, T=0 for 3 edges starting from Q=0 -> Q stays 0 on every edge.
//   3. Toggle: T=1 for 4 edges from Q=0 -> Q sequence 1,0,1,0; Q_n always ~Q.
//   4. Reset mid-run: toggle until Q=1, then assert reset_async=1 with T=1 for one edge -> Q=0.
//      Deassert reset with T=1 -> next edge Q=1.
//   5. Reset timing: pulse reset_async=1 only between edges (high at no posedge) -> Q unaffected.
//   6. Random: 20 cycles of random T, WIDTH=1 and WIDTH=8 -> every edge satisfies Q == Q_prev ^ T.
//      Also covers simultaneous toggling of all bits with T=8'hFF from 8'h00 -> 8'hFF.

Source files
------------

// File: rtl/toggle_ff_posedge_if.sv
// Bus bundle for the toggle flip-flop bank: per-bit toggle requests in,
// registered state and its complement out.
interface toggle_ff_posedge_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_n;

  modport master (output T, input Q, input Q_n);
  modport slave  (input T, output Q, output Q_n);
endinterface

// File: rtl/toggle_ff_posedge.sv
// Bank of WIDTH independent T flip-flops on posedge clk; each bit inverts when
// its T is 1 and holds when 0. Reset is synchronous despite the port name.
module toggle_ff_posedge #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset_async,
  toggle_ff_posedge_if.slave  bus
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_n;

  // State register: reset wins over any toggle request sampled at the same edge
  always_ff @(posedge clk) begin
    if (reset_async) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= r_q ^ bus.T;
    end
  end

  assign w_q_n  = ~r_q;
  assign bus.Q   = r_q;
  assign bus.Q_n = w_q_n;

endmodule

// File: tb/tb_toggle_ff_posedge.sv
// Self-checking bench: three instances (1-bit reset 0, 1-bit reset 1, 8-bit)
// checked every cycle against a behavioural model plus literal expectations.
module tb_toggle_ff_posedge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  toggle_ff_posedge_if #(.WIDTH(1)) if_a ();
  toggle_ff_posedge_if #(.WIDTH(1)) if_b ();
  toggle_ff_posedge_if #(.WIDTH(8)) if_c ();

  toggle_ff_posedge #(.WIDTH(1), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .reset_async(rst), .bus(if_a.slave));
  toggle_ff_posedge #(.WIDTH(1), .RESET_VAL(1'b1)) dut_b (
    .clk(clk), .reset_async(rst), .bus(if_b.slave));
  toggle_ff_posedge #(.WIDTH(8), .RESET_VAL(8'h00)) dut_c (
    .clk(clk), .reset_async(rst), .bus(if_c.slave));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an edge either loads the reset value or XORs in T
  logic       m_a, m_b;
  logic [7:0] m_c;
  bit         m_valid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_a     <= 1'b0;
      m_b     <= 1'b1;
      m_c     <= 8'h00;
      m_valid <= 1'b1;
    end else begin
      m_a <= m_a ^ if_a.T;
      m_b <= m_b ^ if_b.T;
      m_c <= m_c ^ if_c.T;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_a_q",  {7'd0, if_a.Q},   {7'd0, m_a});
      chk("model_a_qn", {7'd0, if_a.Q_n}, {7'd0, ~m_a});
      chk("model_b_q",  {7'd0, if_b.Q},   {7'd0, m_b});
      chk("model_b_qn", {7'd0, if_b.Q_n}, {7'd0, ~m_b});
      chk("model_c_q",  if_c.Q,   m_c);
      chk("model_c_qn", if_c.Q_n, ~m_c);
    end
  end

  task automatic step(input logic r, input logic t1, input logic [7:0] t8);
    rst    = r;
    if_a.T = t1;
    if_b.T = t1;
    if_c.T = t8;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] prev_c;
  logic       prev_a;
  logic [7:0] rnd;

  initial begin
    if_a.T = 1'b1;
    if_b.T = 1'b1;
    if_c.T = 8'hFF;

    // 1. reset with T=1
    step(1'b1, 1'b1, 8'hFF);
    chk("reset_q0",   {7'd0, if_a.Q},   8'h00);
    chk("reset_qn0",  {7'd0, if_a.Q_n}, 8'h01);
    chk("reset_q1",   {7'd0, if_b.Q},   8'h01);
    chk("reset_q8",   if_c.Q,           8'h00);

    // 2. hold for 3 edges
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00);
      chk("hold_q", {7'd0, if_a.Q}, 8'h00);
    end

    // 3. toggle 4 edges: 1,0,1,0; 8-bit all-ones from 00 -> FF on first edge
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'hFF);
      chk("toggle_q",  {7'd0, if_a.Q},   (i % 2 == 0) ? 8'h01 : 8'h00);
      chk("toggle_qn", {7'd0, if_a.Q_n}, (i % 2 == 0) ? 8'h00 : 8'h01);
      if (i == 0) chk("toggle_all_ff", if_c.Q, 8'hFF);
    end

    // 4. reset mid-run
    step(1'b0, 1'b1, 8'h0F);
    chk("mid_pre_q", {7'd0, if_a.Q}, 8'h01);
    step(1'b1, 1'b1, 8'hFF);
    chk("mid_rst_q",  {7'd0, if_a.Q}, 8'h00);
    chk("mid_rst_q1", {7'd0, if_b.Q}, 8'h01);
    chk("mid_rst_q8", if_c.Q,         8'h00);
    step(1'b0, 1'b1, 8'h81);
    chk("mid_resume_q",  {7'd0, if_a.Q}, 8'h01);
    chk("mid_resume_q8", if_c.Q,         8'h81);

    // 5. reset pulse strictly between edges has no effect
    if_a.T = 1'b0;
    if_b.T = 1'b0;
    if_c.T = 8'h00;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("pulse_between_q", {7'd0, if_a.Q}, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    chk("pulse_after_q",  {7'd0, if_a.Q}, 8'h01);
    chk("pulse_after_q8", if_c.Q,         8'h81);

    // 6. random T, every edge Q == Q_prev ^ T
    for (int i = 0; i < 20; i++) begin
      rnd    = 8'($urandom);
      prev_a = if_a.Q;
      prev_c = if_c.Q;
      step(1'b0, rnd[0], rnd);
      chk("rand_q1", {7'd0, if_a.Q}, {7'd0, prev_a ^ rnd[0]});
      chk("rand_q8", if_c.Q,         prev_c ^ rnd);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
